// File: rtl/ultrasonic_scan_scheduler.sv
// ultrasonic_scan_scheduler: round-robin HC-SR04 scan controller. One echo timer
// is shared by NUM_SENSORS sensors; one trigger fires per slot and the echo width
// is converted to centimetres (58 us per cm) with saturation.
// Optional build macro: ULTRASONIC_SCAN_AVG_EN (average each normal result with the
// previous one for that sensor).
module ultrasonic_scan_scheduler #(
  parameter int unsigned NUM_SENSORS = 4,
  parameter int unsigned CLK_HZ      = 125_000_000,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned TIMEOUT_US  = 25000,
  parameter int unsigned SLOT_US     = 60000,
  parameter int unsigned DIST_W      = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_SENSORS-1:0]        echo,
  output logic [NUM_SENSORS-1:0]        trig,
  output logic [NUM_SENSORS*DIST_W-1:0] dist_cm,
  output logic                          valid,
  output logic [2:0]                    sensor_id,
  output logic [NUM_SENSORS-1:0]        timeout_flag,
  output logic                          busy
);

  localparam int unsigned DIV       = CLK_HZ / 1_000_000;
  localparam int unsigned PRESC_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned MAX_US    = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int unsigned US_W      = $clog2(MAX_US + 1);
  localparam int unsigned SLOT_W    = $clog2(SLOT_US + 1);
  localparam int unsigned IDX_W     = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int unsigned SUB_W     = 6;
  localparam int unsigned US_PER_CM = 58;
  localparam int unsigned BUS_W     = NUM_SENSORS * DIST_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [NUM_SENSORS-1:0] echo_m, echo_s, echo_d;
  logic [PRESC_W-1:0]     presc, slot_presc;
  logic [US_W-1:0]        us_cnt;
  logic [SLOT_W-1:0]      slot_us;
  logic [SUB_W-1:0]       sub_cnt;
  logic [DIST_W-1:0]      cm_cnt, cm_now, wr_val;
  logic [IDX_W-1:0]       cur, cur_d;
  logic                   us_tick, slot_tick, slot_done;
  logic                   rise, fall, trig_done, timed_out;
  logic                   state_entry, slot_start;
  logic                   rec_ok, rec_to;
  logic [NUM_SENSORS-1:0] trig_d, flag_d;
  logic [BUS_W-1:0]       dist_d;
  logic                   valid_d, busy_d;

  // Two-flop synchroniser plus edge-reference register for every echo line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_d <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign rise        = echo_s[cur] & ~echo_d[cur];
  assign fall        = ~echo_s[cur] & echo_d[cur];
  assign us_tick     = (presc == PRESC_W'(DIV - 1));
  assign slot_tick   = (slot_presc == PRESC_W'(DIV - 1));
  assign trig_done   = us_tick && (us_cnt == US_W'(TRIG_US - 1));
  assign timed_out   = us_tick && (us_cnt == US_W'(TIMEOUT_US - 1));
  assign slot_done   = (slot_us == SLOT_W'(SLOT_US)) ||
                       (slot_tick && (slot_us == SLOT_W'(SLOT_US - 1)));
  assign state_entry = (state_next != state);
  assign slot_start  = state_entry && (state_next == TRIG);
  assign cm_now      = (us_tick && (sub_cnt == SUB_W'(US_PER_CM - 1)) && (cm_cnt != '1)) ?
                       cm_cnt + DIST_W'(1) : cm_cnt;

  // Per-state microsecond timebase; restarts on every state entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (state_entry) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (us_tick) begin
      presc  <= '0;
      us_cnt <= us_cnt + US_W'(1);
    end else begin
      presc  <= presc + PRESC_W'(1);
    end
  end

  // Slot timer from trigger rise to next trigger rise; saturates at the slot length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_presc <= '0;
      slot_us    <= '0;
    end else if (slot_start) begin
      slot_presc <= '0;
      slot_us    <= '0;
    end else if (slot_tick) begin
      slot_presc <= '0;
      if (slot_us != SLOT_W'(SLOT_US)) slot_us <= slot_us + SLOT_W'(1);
    end else begin
      slot_presc <= slot_presc + PRESC_W'(1);
    end
  end

  // Echo-width to centimetre converter, active only while measuring
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else if (state_entry) begin
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else if ((state == MEASURE) && us_tick) begin
      sub_cnt <= (sub_cnt == SUB_W'(US_PER_CM - 1)) ? '0 : sub_cnt + SUB_W'(1);
      cm_cnt  <= cm_now;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; a falling edge has priority over a coincident timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (en) state_next = TRIG;
      TRIG:      if (trig_done) state_next = WAIT_RISE;
      WAIT_RISE: begin
        if (rise)           state_next = MEASURE;
        else if (timed_out) state_next = HOLDOFF;
      end
      MEASURE:   if (fall || timed_out) state_next = HOLDOFF;
      HOLDOFF:   if (slot_done) state_next = en ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

`ifdef ULTRASONIC_SCAN_AVG_EN
  logic [DIST_W-1:0] prev_val;
  logic [DIST_W:0]   avg_sum;

  // Blend a new reading with the previous one unless that slot holds no valid reading
  always_comb begin
    prev_val = dist_cm[cur*DIST_W +: DIST_W];
    avg_sum  = (DIST_W+1)'(cm_now) + (DIST_W+1)'(prev_val) + (DIST_W+1)'(1);
    wr_val   = (timeout_flag[cur] || (prev_val == '0)) ? cm_now : DIST_W'(avg_sum >> 1);
  end
`else
  assign wr_val = cm_now;
`endif

  // Output next-values: trigger, result write-back, slot advance
  always_comb begin
    cur_d   = cur;
    trig_d  = '0;
    valid_d = 1'b0;
    busy_d  = (state_next != IDLE);
    dist_d  = dist_cm;
    flag_d  = timeout_flag;
    rec_ok  = (state == MEASURE) && fall;
    rec_to  = ((state == WAIT_RISE) && !rise && timed_out) ||
              ((state == MEASURE) && !fall && timed_out);
    if ((state == HOLDOFF) && slot_done)
      cur_d = (cur == IDX_W'(NUM_SENSORS - 1)) ? '0 : cur + IDX_W'(1);
    if (state_next == TRIG) trig_d[cur_d] = 1'b1;
    if (rec_to) begin
      dist_d[cur*DIST_W +: DIST_W] = '1;
      flag_d[cur]                  = 1'b1;
      valid_d                      = 1'b1;
    end else if (rec_ok) begin
      dist_d[cur*DIST_W +: DIST_W] = wr_val;
      flag_d[cur]                  = 1'b0;
      valid_d                      = 1'b1;
    end
  end

  // Output registers; reset drops the trigger immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur          <= '0;
      trig         <= '0;
      valid        <= 1'b0;
      busy         <= 1'b0;
      dist_cm      <= '0;
      timeout_flag <= '0;
    end else begin
      cur          <= cur_d;
      trig         <= trig_d;
      valid        <= valid_d;
      busy         <= busy_d;
      dist_cm      <= dist_d;
      timeout_flag <= flag_d;
    end
  end

  assign sensor_id = 3'(cur);

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// tb_ultrasonic_scan_scheduler: slot-by-slot stimulus with a behavioural model of
// expected distances, flags and result timing. Timeouts and slot length are scaled
// down so the whole run stays short.
module tb_ultrasonic_scan_scheduler;

  localparam int NS         = 4;
  localparam int CLK_HZ     = 1_000_000;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 1200;
  localparam int SLOT_US    = 1700;
  localparam int DIST_W     = 4;
  localparam int DMAX       = (1 << DIST_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic [NS-1:0]          echo;
  logic [NS-1:0]          trig;
  logic [NS*DIST_W-1:0]   dist_cm;
  logic                   valid;
  logic [2:0]             sensor_id;
  logic [NS-1:0]          timeout_flag;
  logic                   busy;

  ultrasonic_scan_scheduler #(
    .NUM_SENSORS(NS),
    .CLK_HZ     (CLK_HZ),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US),
    .SLOT_US    (SLOT_US),
    .DIST_W     (DIST_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .echo        (echo),
    .trig        (trig),
    .dist_cm     (dist_cm),
    .valid       (valid),
    .sensor_id   (sensor_id),
    .timeout_flag(timeout_flag),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle stamps of every valid pulse
  int valid_q[$];
  always @(negedge clk) if (valid === 1'b1) valid_q.push_back(cyc);

  int checks = 0;
  int errors = 0;
  int m_dist[NS];
  bit m_flag[NS];
  int prev_rise = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_dist_bus();
    logic [NS*DIST_W-1:0] p;
    p = '0;
    for (int i = 0; i < NS; i++) p[i*DIST_W +: DIST_W] = DIST_W'(m_dist[i]);
    return 32'(p);
  endfunction

  function automatic logic [31:0] exp_flag_bus();
    logic [NS-1:0] p;
    p = '0;
    for (int i = 0; i < NS; i++) p[i] = m_flag[i];
    return 32'(p);
  endfunction

  // Reference: cm = floor(high_us / 58), saturated; timeout writes all-ones
  task automatic model_result(input int id, input bit to, input int high_us);
    int v;
    if (to) begin
      m_dist[id] = DMAX;
      m_flag[id] = 1'b1;
    end else begin
      v = high_us / 58;
      if (v > DMAX) v = DMAX;
`ifdef ULTRASONIC_SCAN_AVG_EN
      if (!m_flag[id] && m_dist[id] != 0) v = (v + m_dist[id] + 1) / 2;
`endif
      m_dist[id] = v;
      m_flag[id] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_dist[i] = 0;
      m_flag[i] = 1'b0;
    end
  endtask

  // One slot: rdly < 0 means no rise; stuck raises echo before the trigger;
  // drop_en > 0 lowers en that many cycles into the echo pulse
  task automatic run_slot(input int id, input int rdly, input int h, input bit stuck,
                          input int drop_en);
    int n, t_rise, t_fall, t_pr, t_pf, exp_t;
    bit to;
    t_pr = 0;
    t_pf = 0;
    if (stuck) echo[id] = 1'b1;
    n = 0;
    while (trig == '0 && n < SLOT_US + 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("trig_seen", 32'(trig != '0), 32'(1));
    if (trig == '0) return;
    t_rise = cyc;
    check_eq("trig_onehot", 32'(trig), 32'(1 << id));
    check_eq("sensor_id", 32'(sensor_id), 32'(id));
    check_eq("busy_in_slot", 32'(busy), 32'(1));
    if (prev_rise >= 0) check_eq("slot_period", 32'(t_rise - prev_rise), 32'(SLOT_US));
    prev_rise = t_rise;
    check_eq("extra_valid", 32'(valid_q.size()), 32'(0));
    valid_q.delete();
    n = 0;
    while (trig != '0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("trig_width", 32'(n), 32'(TRIG_US));
    t_fall = cyc;
    if (rdly >= 0) begin
      repeat (rdly) @(posedge clk);
      #1 echo[id] = 1'b1;
      t_pr = cyc;
      if (drop_en > 0) begin
        repeat (drop_en) @(posedge clk);
        #1 en = 1'b0;
        repeat (h - drop_en) @(posedge clk);
      end else begin
        repeat (h) @(posedge clk);
      end
      #1 echo[id] = 1'b0;
      t_pf = cyc;
    end
    to = (rdly < 0) || (h > TIMEOUT_US);
    if (rdly < 0)            exp_t = t_fall + TIMEOUT_US;
    else if (h > TIMEOUT_US) exp_t = t_pr + 3 + TIMEOUT_US;
    else                     exp_t = t_pf + 3;
    n = 0;
    while (valid_q.size() == 0 && n < SLOT_US) begin
      @(negedge clk);
      n++;
    end
    check_eq("valid_seen", 32'(valid_q.size() != 0), 32'(1));
    if (valid_q.size() != 0) begin
      check_eq("valid_time", 32'(valid_q[0]), 32'(exp_t));
      void'(valid_q.pop_front());
    end
    model_result(id, to, h);
    check_eq("dist_cm", 32'(dist_cm), exp_dist_bus());
    check_eq("timeout_flag", 32'(timeout_flag), exp_flag_bus());
    if (stuck) echo[id] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, slot, any_trig;
    rst  = 1'b0;
    en   = 1'b0;
    echo = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_trig", 32'(trig), 32'(0));
    check_eq("rst_dist", 32'(dist_cm), 32'(0));
    check_eq("rst_valid", 32'(valid), 32'(0));
    check_eq("rst_sensor_id", 32'(sensor_id), 32'(0));
    check_eq("rst_flag", 32'(timeout_flag), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'(0));
    check_eq("idle_trig", 32'(trig), 32'(0));
    @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk);

    run_slot(0, 200, 580, 1'b0, 0);   // basic: 10 cm
    run_slot(1, -1, 0, 1'b0, 0);      // no echo
    run_slot(2, -1, 0, 1'b1, 0);      // echo stuck high
    run_slot(3, 50, 290, 1'b0, 0);    // 5 cm
    run_slot(0, 50, 696, 1'b0, 0);    // 12 cm
    run_slot(1, 100, 580, 1'b0, 0);   // after a timeout
    run_slot(2, 100, 1500, 1'b0, 0);  // echo too long
    run_slot(3, 20, TIMEOUT_US, 1'b0, 0);      // fall coincides with timeout
    run_slot(0, 20, TIMEOUT_US + 1, 1'b0, 0);  // one past the timeout
    run_slot(1, 30, 1000, 1'b0, 0);   // saturates
    for (slot = 10; slot < 15; slot++)
      run_slot(slot % NS, int'($urandom_range(1, 300)), int'($urandom_range(1, 1300)), 1'b0, 0);

    // Reset five cycles into the trigger of sensor 3
    n = 0;
    while (trig == '0 && n < SLOT_US + 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("pre_rst_trig", 32'(trig), 32'(8));
    repeat (5) @(posedge clk);
    #1 check_eq("trig_mid_pulse", 32'(trig), 32'(8));
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_trig", 32'(trig), 32'(0));
    check_eq("mid_rst_dist", 32'(dist_cm), 32'(0));
    check_eq("mid_rst_valid", 32'(valid), 32'(0));
    check_eq("mid_rst_sensor_id", 32'(sensor_id), 32'(0));
    check_eq("mid_rst_flag", 32'(timeout_flag), 32'(0));
    check_eq("mid_rst_busy", 32'(busy), 32'(0));
    model_reset();
    prev_rise = -1;
    valid_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // en dropped while measuring: slot completes, then the scheduler parks
    run_slot(0, 100, 580, 1'b0, 300);
    while (cyc < prev_rise + SLOT_US - 1) @(negedge clk);
    check_eq("holdoff_busy", 32'(busy), 32'(1));
    @(negedge clk);
    check_eq("stop_busy", 32'(busy), 32'(0));
    check_eq("stop_trig", 32'(trig), 32'(0));
    check_eq("stop_sensor_id", 32'(sensor_id), 32'(1));
    any_trig = 0;
    repeat (300) begin
      @(negedge clk);
      if (trig != '0) any_trig = 1;
    end
    check_eq("no_trig_after_stop", 32'(any_trig), 32'(0));
    check_eq("no_valid_after_stop", 32'(valid_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ultrasonic_scan_scheduler.md
Name: ultrasonic_scan_scheduler

Overview:
Round-robin scan controller that shares one echo-timing datapath among NUM_SENSORS HC-SR04 sensors.
- Fires one trigger at a time and measures that sensor's echo pulse width in centimetres.
- Enforces the per-slot repetition period and timeouts.
- Publishes per-sensor distances for the binary-to-BCD / 4-digit FND display chain and the LED bar logic.

Parameters:
NUM_SENSORS, 4, number of sensors scanned; 1..8
CLK_HZ, 125_000_000, clk frequency; must be an integer multiple of 1_000_000
TRIG_US, 10, trigger pulse width in us
TIMEOUT_US, 25000, maximum wait for echo rise, and maximum echo high time, in us
SLOT_US, 60000, slot period in us, measured from trigger rise to the next trigger rise
DIST_W, 12, distance width in bits; saturation value is 2^DIST_W-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
en  in  1  scan enable
echo  in  NUM_SENSORS  raw echo inputs; asynchronous
trig  out  NUM_SENSORS  trigger outputs; one-hot or zero
dist_cm  out  NUM_SENSORS*DIST_W  sensor i occupies bits [i*DIST_W +: DIST_W]
valid  out  1  one-cycle pulse when a slot result is written
sensor_id  out  3  index of the current or last slot
timeout_flag  out  NUM_SENSORS  set means the last result of sensor i timed out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE; trig=0, dist_cm=0, valid=0, sensor_id=0, timeout_flag=0, busy=0.
  - all counters and echo synchronisers cleared.
  - Trig drops immediately, even mid-pulse.
- Echo inputs:
  - Each echo input passes through a 2-flop synchroniser.
  - Edges are detected on the synchronised signal against a registered copy.
- Timebase:
  - us_tick pulses once every CLK_HZ/1_000_000 cycles.
  - The us_tick prescaler restarts on every state entry.
- States:
  - IDLE: if en=1, go to TRIG with sensor_id unchanged.
  - TRIG:
    - trig[sensor_id]=1 for exactly TRIG_US*CLK_HZ/1e6 cycles.
    - The slot counter starts at trig rise.
    - Then go to WAIT_RISE.
  - WAIT_RISE:
    - On a rising edge of the synchronised echo[sensor_id], go to MEASURE.
    - If TIMEOUT_US us elapse first, record a timeout.
    - An echo already high on entry is not a rise; a clean low-to-high edge is required.
  - MEASURE:
    - A sub-counter counts us_tick; every 58 ticks the cm counter increments, saturating at 2^DIST_W-1.
    - On a falling edge, record the cm counter.
    - If TIMEOUT_US us of echo high elapse, record a timeout.
  - Record (single cycle, in the exit cycle of WAIT_RISE/MEASURE):
    - Normal result: write the slot value to dist_cm[sensor_id], pulse valid=1, clear timeout_flag[sensor_id].
    - Timeout: write all-ones instead and set timeout_flag[sensor_id].
    - Then go to HOLDOFF.
  - HOLDOFF:
    - Wait until the slot counter reaches SLOT_US.
    - Then sensor_id = (sensor_id==NUM_SENSORS-1) ? 0 : sensor_id+1.
    - If en=1, go to TRIG; otherwise go to IDLE.
- Latency: echo pin fall to valid is 3 cycles (2 synchroniser + 1 edge register), with the write in the same cycle as valid.
- Echo on non-selected sensors is ignored.
- Deasserting en mid-slot completes the current slot; the scheduler stops only at the HOLDOFF exit.
- If the falling edge and the timeout expiry occur in the same cycle, the falling edge wins and a normal result is recorded.
- dist_cm slices hold their value until rewritten.
- Sensor slots other than sensor_id are never modified.

Optional Feature:
Macro: ULTRASONIC_SCAN_AVG_EN
- Defined: a normal result is written as (new + previous + 1) >> 1, computed in DIST_W+1 bits.
  - When the previous result was a timeout or reset value 0, the new value is written directly.
  - A timeout still writes all-ones and is never averaged.
- Undefined: the raw result is written.

Test Plan:
(Parameters for all scenarios: CLK_HZ=1_000_000, NUM_SENSORS=4, TRIG_US=10, TIMEOUT_US=25000, SLOT_US=60000.)
- Basic measurement:
  - Stimulus: rst 0->1, en=1; echo[0] rises 200 us after trig fall and stays high 5800 us.
  - Required: trig[0] high exactly 10 cycles; valid 3 cycles after the echo fall; dist_cm[11:0]=100; timeout_flag[0]=0.
- Round robin:
  - Stimulus: all sensors echo 1160 us.
  - Required: trig order 0,1,2,3,0; trig rises spaced exactly 60000 cycles; every slice = 20.
- No echo:
  - Stimulus: echo[1] held low.
  - Required: 25000 us after trig fall, dist_cm[23:12]=4095, timeout_flag[1]=1, valid pulses once.
- Echo stuck high:
  - Stimulus: echo[2] high before trig.
  - Required: no MEASURE entry; timeout result 4095.
- Echo too long:
  - Stimulus: echo[2] rises normally and stays high 30000 us.
  - Required: timeout after 25000 us; result 4095.
- Reset and enable control:
  - Stimulus 1: reset asserted 5 cycles into trig[3].
    - Required: trig=0 that same cycle; all outputs 0.
  - Stimulus 2: after reset release with en=1, en dropped during MEASURE.
    - Required: result still written; IDLE reached after the slot ends; no further trig.
- AVG_EN:
  - Stimulus: sensor 0 echoes 100 cm, then 200 cm.
  - Required: results 100, then 150.
